// File: rtl/serial_fs.sv
// Bit-serial full subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_FS_OVF_EN to add the signed-overflow output ovf.
module serial_fs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_FS_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] ra_reg;
  logic [WIDTH-1:0] rb_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] diff_next;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             bout_reg;
  logic             d_bit;
  logic             br_next;
  logic             hd;

  // Full-subtractor cell: two half subtractors, borrows ORed together.
  assign hd      = ra_reg[0] ^ rb_reg[0];
  assign d_bit   = hd ^ br_reg;
  assign br_next = (~ra_reg[0] & rb_reg[0]) | (~hd & br_reg);

  // diff shifts right with the new bit entering at the MSB.
  assign diff_next[WIDTH-1] = d_bit;
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_dshift
      assign diff_next[gi] = diff_reg[gi+1];
    end
  endgenerate

`ifdef SERIAL_FS_OVF_EN
  logic ovf_reg;
  assign ovf = ovf_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ra_reg    <= '0;
      rb_reg    <= '0;
      diff_reg  <= '0;
      cnt_reg   <= '0;
      br_reg    <= 1'b0;
      bout_reg  <= 1'b0;
`ifdef SERIAL_FS_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            ra_reg    <= a;
            rb_reg    <= b;
            br_reg    <= bin;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          ra_reg   <= ra_reg >> 1;
          rb_reg   <= rb_reg >> 1;
          diff_reg <= diff_next;
          br_reg   <= br_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            bout_reg  <= br_next;
`ifdef SERIAL_FS_OVF_EN
            // Borrow into the MSB differing from borrow out marks signed overflow.
            ovf_reg   <= br_reg ^ br_next;
`endif
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == SHIFT);
  assign out_valid = (state_reg == HOLD);
  assign diff      = diff_reg;
  assign bout      = bout_reg;

endmodule

// File: tb/tb_serial_fs.sv
// Directed testbench for serial_fs: WIDTH=8 and WIDTH=1 instances on one clock.
// With SERIAL_FS_OVF_EN defined the ovf output is checked as well.
module tb_serial_fs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, busy8, out_valid8, bout8;
  logic [7:0] diff8;
  logic       in_valid1 = 1'b0, out_ready1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       in_ready1, busy1, out_valid1, bout1;
  logic [0:0] diff1;
`ifdef SERIAL_FS_OVF_EN
  logic       ovf8, ovf1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_fs #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .busy(busy8), .out_valid(out_valid8),
    .out_ready(out_ready8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_FS_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_fs #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .busy(busy1), .out_valid(out_valid1),
    .out_ready(out_ready1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_FS_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation; hold>0 keeps out_ready low that many cycles and
  // pulses a stray in_valid on the first of them.
  task automatic run_op(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                        input logic obin, input logic [7:0] ediff, input logic ebout,
                        input logic eovf, input int hold);
    int n;
    int busy_n;
    n = 0;
    while (!in_ready8 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, {31'd0, in_ready8}, 32'd1);
    a8 = oa; b8 = ob; bin8 = obin; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    busy_n = 0;
    n = 0;
    while (!out_valid8 && n < 20) begin
      if (busy8) busy_n++;
      tick();
      n++;
    end
    $display("op %s a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d lat=%0d", tag, oa, ob, obin, diff8, bout8, n);
    check({tag, "_lat"}, n, 32'd8);
    check({tag, "_busy"}, busy_n, 32'd8);
    check({tag, "_diff"}, {24'd0, diff8}, {24'd0, ediff});
    check({tag, "_bout"}, {31'd0, bout8}, {31'd0, ebout});
`ifdef SERIAL_FS_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("unused ovf expectation");
`endif
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        a8 = 8'h12; b8 = 8'h34; bin8 = 1'b1; in_valid8 = 1'b1;
      end
      tick();
      in_valid8 = 1'b0;
      check({tag, "_hold_ov"}, {31'd0, out_valid8}, 32'd1);
      check({tag, "_hold_rdy"}, {31'd0, in_ready8}, 32'd0);
      check({tag, "_hold_diff"}, {24'd0, diff8}, {24'd0, ediff});
      check({tag, "_hold_bout"}, {31'd0, bout8}, {31'd0, ebout});
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check({tag, "_rel_rdy"}, {31'd0, in_ready8}, 32'd1);
    check({tag, "_rel_ov"}, {31'd0, out_valid8}, 32'd0);
    check({tag, "_rel_busy"}, {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    int last;
    int seen;
    #12;
    check("rst_ready", {31'd0, in_ready8}, 32'd1);
    check("rst_ov", {31'd0, out_valid8}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_diff", {24'd0, diff8}, 32'd0);
    check("rst_bout", {31'd0, bout8}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 0);
    run_op("t2", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
    run_op("t3", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op("bp", 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 5);
    // The stray in_valid during HOLD must not have started a new operation.
    tick();
    check("bp_idle", {31'd0, busy8}, 32'd0);

    // Reset three cycles into SHIFT.
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick(); tick(); tick();
    check("mid_busy_pre", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_ov", {31'd0, out_valid8}, 32'd0);
    check("mid_diff", {24'd0, diff8}, 32'd0);
    check("mid_bout", {31'd0, bout8}, 32'd0);
    check("mid_busy", {31'd0, busy8}, 32'd0);
    check("mid_ready", {31'd0, in_ready8}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("post", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);

    run_op("ov1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    run_op("ov2", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
    run_op("ov3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);

    // WIDTH=1: single accept, result one cycle later.
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b1; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("w1_busy", {31'd0, busy1}, 32'd1);
    tick();
    $display("op w1 a=0 b=1 bin=1 -> diff=%0d bout=%0d ov=%0d", diff1, bout1, out_valid1);
    check("w1_ov", {31'd0, out_valid1}, 32'd1);
    check("w1_diff", {31'd0, diff1}, 32'd0);
    check("w1_bout", {31'd0, bout1}, 32'd1);
    out_ready1 = 1'b1;
    tick();
    check("w1_rel", {31'd0, in_ready1}, 32'd1);

    // WIDTH=1 back-to-back: in_valid and out_ready held high.
    a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0; in_valid1 = 1'b1;
    last = -1;
    seen = 0;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (out_valid1) begin
        seen++;
        $display("op w1b#%0d cycle=%0d diff=%0d bout=%0d", seen, c, diff1, bout1);
        check("w1b_diff", {31'd0, diff1}, 32'd1);
        check("w1b_bout", {31'd0, bout1}, 32'd0);
        if (last >= 0) check("w1b_gap", c - last, 32'd3);
        last = c;
      end
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    check("w1b_count", seen, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
